// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the main decoder:
// FSM state encoding, primary opcodes and the default reset PC.
package fetch_unit_pkg;

  // Fetch FSM states (1-bit encoding)
  typedef enum logic [0:0] {
    FS_REQ   = 1'b0,  // request outstanding on the instruction bus
    FS_ISSUE = 1'b1   // instruction held and valid
  } fetch_state_e;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction fetches are word aligned; the two low address bits are dropped
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and memory (slave).
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// 32-bit program-counter register with asynchronous reset and load enable.
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);

  logic [31:0] pc_q;

  // Hold the PC; load a new value only when enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VAL;
    end else if (en_i) begin
      pc_q <= d_i;
    end else begin
      pc_q <= pc_q;
    end
  end

  assign q_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Two-state instruction fetch unit: requests the word at PC, holds it until
// downstream accepts, then advances PC (sequential, branch or jump). An
// optional timeout drops and re-issues a request that memory never answers.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                reset,
  fetch_unit_if.master        imem,
  input  logic                stall_i,
  input  logic                branch_taken_i,
  input  logic [31:0]         branch_target_i,
  output logic [31:0]         instr_o,
  output logic [5:0]          op_o,
  output logic                instr_valid_o,
  output logic [31:0]         pcplus4_o
);

  localparam logic [0:0] S_REQ   = FS_REQ;
  localparam logic [0:0] S_ISSUE = FS_ISSUE;

  // A zero timeout disables the counter; keep it one bit wide in that case
  localparam int unsigned   TW        = (IMEM_TIMEOUT > 0) ? $clog2(IMEM_TIMEOUT + 1) : 1;
  localparam bit            TMO_EN    = (IMEM_TIMEOUT > 0);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(IMEM_TIMEOUT);

  logic [0:0]    state_q, state_d;
  logic [31:0]   instr_q, instr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          drop_q, drop_d;

  logic [31:0]   pc;
  logic [31:0]   pcplus4;
  logic [31:0]   next_pc;
  logic          pc_load;
  logic          req_active;

  assign pcplus4    = pc + 32'd4;
  assign req_active = (state_q == S_REQ) && !drop_q;

  pc_reg #(
    .RESET_VAL (word_align(RESET_PC))
  ) u_pc_reg (
    .clk  (clk),
    .rst  (reset),
    .en_i (pc_load),
    .d_i  (next_pc),
    .q_o  (pc)
  );

  // Next-PC select: jump beats a taken branch, otherwise fall through
  always_comb begin
    if (instr_q[31:26] == OP_J) begin
      next_pc = {pcplus4[31:28], instr_q[25:0], 2'b00};
    end else if (branch_taken_i) begin
      next_pc = word_align(branch_target_i);
    end else begin
      next_pc = pcplus4;
    end
  end

  // FSM transitions, instruction capture and request timeout
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    tmo_d   = tmo_q;
    drop_d  = 1'b0;
    pc_load = 1'b0;
    case (state_q)
      S_REQ: begin
        if (drop_q) begin
          // request withdrawn for this cycle; re-issue at the same PC next
          tmo_d = '0;
        end else if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          state_d = S_ISSUE;
          tmo_d   = '0;
        end else if (TMO_EN && ((tmo_q + TW'(1)) == TMO_LIMIT)) begin
          drop_d = 1'b1;
          tmo_d  = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_ISSUE: begin
        // redirect inputs only matter on the edge the instruction is released
        if (!stall_i) begin
          pc_load = 1'b1;
          state_d = S_REQ;
          tmo_d   = '0;
        end else begin
          state_d = S_ISSUE;
        end
      end
      default: begin
        state_d = S_REQ;
        tmo_d   = '0;
      end
    endcase
  end

  // State registers; reset discards any outstanding or held fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_REQ;
      instr_q <= 32'h0000_0000;
      tmo_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      tmo_q   <= tmo_d;
      drop_q  <= drop_d;
    end
  end

  // No request is presented while reset is held
  assign imem.imem_req  = req_active && !reset;
  assign imem.imem_addr = pc;

  assign instr_o       = instr_q;
  assign op_o          = instr_q[31:26];
  assign instr_valid_o = (state_q == S_ISSUE);
  assign pcplus4_o     = pcplus4;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetched instruction after reset.
REQ-002 Parameter IMEM_TIMEOUT, default 0 (disabled), max wait cycles on imem_ready before the fetch is re-issued.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address (= PC).
REQ-007 imem_ready  input  1  instruction memory returns imem_rdata this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 stall  input  1  downstream not ready; hold current instruction.
REQ-010 branch_taken  input  1  decoder/datapath taken-branch indication for the held instruction.
REQ-011 branch_target  input  32  branch destination address.
REQ-012 instr  output  32  instruction register contents.
REQ-013 op  output  6  instr[31:26], feeds the main decoder.
REQ-014 instr_valid  output  1  instr/op hold a fetched instruction.
REQ-015 pcplus4  output  32  PC of held instruction + 4.

Function
REQ-016 FSM states: REQ (request outstanding), ISSUE (instruction held, valid); encoding 1 bit.
REQ-017 REQ: imem_req=1, imem_addr=PC, instr_valid=0; on imem_ready=1 capture imem_rdata into instr at that edge and go to ISSUE.
REQ-018 Fetch latency: instr_valid rises the cycle after the cycle imem_ready=1 is sampled in REQ; minimum 2 cycles per instruction.
REQ-019 ISSUE: imem_req=0, instr_valid=1; instr, op, pcplus4 stable while stall=1.
REQ-020 ISSUE with stall=0: update PC and go to REQ on the same edge; redirect inputs are sampled only then.
REQ-021 Next-PC priority: jump (op=6'b000010) -> {pcplus4[31:28], instr[25:0], 2'b00}; else branch_taken -> branch_target; else pcplus4.
REQ-022 PC arithmetic is modulo 2^32: PC 32'hFFFF_FFFC sequential next = 32'h0000_0000.
REQ-023 PC[1:0] forced to 2'b00; branch_target[1:0] ignored.
REQ-024 imem_ready in ISSUE is ignored; imem_rdata is never captured outside REQ.
REQ-025 branch_taken and jump in the same cycle: jump wins.
REQ-026 IMEM_TIMEOUT>0: counter counts REQ cycles without imem_ready; on reaching IMEM_TIMEOUT, imem_req drops for exactly one cycle, counter clears, request re-issued at same PC.
REQ-027 Timeout counter clears on entry to REQ and on imem_ready; width $clog2(IMEM_TIMEOUT+1).

Reset
REQ-028 reset asserted: immediately (asynchronously) PC=RESET_PC, state=REQ, instr=32'h0, instr_valid=0, timeout counter=0.
REQ-029 During reset imem_req=0; first imem_req=1 in the first cycle after reset deasserts, imem_addr=RESET_PC.
REQ-030 Reset mid-REQ or mid-ISSUE discards the outstanding fetch/held instruction; a late imem_ready after reset is treated as response to the new RESET_PC request only if sampled in REQ after deassertion.

Structure
REQ-031 Shared package holds: FSM state enum, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J) also used by the decoder, default RESET_PC.
REQ-032 One sub-module: pc_reg, 32-bit async-reset register with load enable, instantiated for PC.
REQ-033 Next-PC mux and jump-target concatenation are combinational inside fetch_unit; no other sub-modules.

Verification
REQ-034 Reset release, imem_ready=1 with imem_rdata=32'h2008_0005 -> imem_addr=0, instr_valid=1 next cycle, op=6'b001000, pcplus4=4.
REQ-035 Held instr 32'h0800_0010 at PC 0x40, stall=0 -> next imem_addr=32'h0000_0040 jump target = 0x0000_0040, i.e. {4'h0, 26'h10, 2'b00}.
REQ-036 Held BEQ, branch_taken=1, branch_target=32'h0000_0103 -> next imem_addr=32'h0000_0100.
REQ-037 stall=1 for 5 cycles in ISSUE with branch_taken toggling -> instr, pcplus4 unchanged, imem_req=0, no PC change until stall=0.
REQ-038 PC=32'hFFFF_FFFC sequential, stall=0 -> next imem_addr=32'h0000_0000.
REQ-039 reset pulsed while in REQ with imem_ready=0, then IMEM_TIMEOUT=3 and no ready -> imem_addr=RESET_PC, imem_req drops one cycle after 3 waiting cycles, then re-asserts.
